// File: rtl/ll_pkg.sv
// Shared types and constants for the linked-list builder.
// Optional build macro: LL_BUILDER_CHECK_EN (structural error checks, see ll_list_builder).
package ll_pkg;
  localparam int N     = 16;
  localparam int W_PTR = $clog2(N);

  typedef logic [W_PTR-1:0] ptr_t;

  localparam ptr_t NULL_PTR = '0;
  localparam ptr_t LAST_PTR = ptr_t'(N-1);

  typedef enum logic {IDLE, WALK} state_t;
endpackage

// File: rtl/ll_next_ram.sv
// next[] pointer table: register array reset to the initial free chain
// 1->2->...->N-1->0, NRD combinational read ports, two write ports.
module ll_next_ram
  import ll_pkg::*;
#(
  parameter int NRD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  ptr_t [NRD-1:0]   raddr,
  output ptr_t [NRD-1:0]   rdata,
  input  logic [1:0]       we,
  input  ptr_t [1:0]       waddr,
  input  ptr_t [1:0]       wdata
);

  ptr_t mem [N];

  // Table update; node 0 is the NULL terminator and is never rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++)
        mem[i] <= (i >= 1 && i <= N-2) ? ptr_t'(i+1) : NULL_PTR;
    end else begin
      for (int k = 0; k < 2; k++)
        if (we[k] && waddr[k] != NULL_PTR) mem[waddr[k]] <= wdata[k];
    end
  end

  // Combinational lookups.
  always_comb begin
    for (int i = 0; i < NRD; i++) rdata[i] = mem[raddr[i]];
  end

  // The controller never targets one address from both write ports.
  a_no_dual_write: assert property (@(posedge clk) disable iff (!rst_n)
    !(we[0] && we[1] && waddr[0] == waddr[1]));

endmodule

// File: rtl/ll_list_builder.sv
// Linked-list writer: owns next[], the free pool and append/free operations.
// Optional build macro: LL_BUILDER_CHECK_EN enables the sticky err checks
// (append to a non-tail, walk loop detection, free into a full pool).
module ll_list_builder
  import ll_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             app_vld,
  input  logic [W_PTR-1:0] app_tail,
  output logic             app_rdy,
  output logic             app_done,
  output logic [W_PTR-1:0] app_ptr,
  input  logic             free_vld,
  input  logic [W_PTR-1:0] free_head,
  output logic             free_rdy,
  output logic             free_done,
  output logic [W_PTR-1:0] free_cnt,
  input  logic [W_PTR-1:0] rd_ptr,
  output logic [W_PTR-1:0] rd_next,
  output logic             err
);

`ifdef LL_BUILDER_CHECK_EN
  localparam int NRD = 3;  // extra port reads next[app_tail]
`else
  localparam int NRD = 2;
`endif

  state_t state_q, state_d;
  ptr_t   cur_q, cur_d, len_q, len_d, head_q, head_d;
  ptr_t   pool_q, pool_d, cnt_q, cnt_d, app_ptr_q, app_ptr_d;
  logic   app_done_q, app_done_d, free_done_q, free_done_d, err_q, err_d;

  ptr_t [NRD-1:0] raddr, rdata;
  logic [1:0]     we;
  ptr_t [1:0]     waddr, wdata;
  logic           tail_bad, loop_bad, full_bad;

  ll_next_ram #(.NRD(NRD)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .raddr (raddr),
    .rdata (rdata),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
  );

  assign app_rdy   = (state_q == IDLE) && (cnt_q != NULL_PTR);
  assign free_rdy  = (state_q == IDLE) && !app_vld;
  assign app_done  = app_done_q;
  assign app_ptr   = app_ptr_q;
  assign free_done = free_done_q;
  assign free_cnt  = cnt_q;
  assign rd_next   = rdata[0];
  assign err       = err_q;

  // Read port 1 follows the walk cursor while walking, else the pool head.
  always_comb begin
    raddr[0] = rd_ptr;
    raddr[1] = (state_q == WALK) ? cur_q : pool_q;
`ifdef LL_BUILDER_CHECK_EN
    raddr[2] = app_tail;
`endif
  end

  // Error conditions; all constant-false when checks are compiled out.
  always_comb begin
`ifdef LL_BUILDER_CHECK_EN
    tail_bad = (app_tail != NULL_PTR) && (rdata[2] != NULL_PTR);
    loop_bad = (len_q == LAST_PTR);
    full_bad = (cnt_q == LAST_PTR);
`else
    tail_bad = 1'b0;
    loop_bad = 1'b0;
    full_bad = 1'b0;
`endif
  end

  // Next-state, table writes and completion pulses.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    len_d       = len_q;
    head_d      = head_q;
    pool_d      = pool_q;
    cnt_d       = cnt_q;
    app_ptr_d   = app_ptr_q;
    err_d       = err_q;
    app_done_d  = 1'b0;
    free_done_d = 1'b0;
    we          = '0;
    waddr       = '0;
    wdata       = '0;
    case (state_q)
      IDLE: begin
        if (app_vld && app_rdy) begin
          app_done_d = 1'b1;
          if (tail_bad) begin
            app_ptr_d = NULL_PTR;
            err_d     = 1'b1;
          end else begin
            // Pop the pool head, terminate it, link it behind the tail.
            app_ptr_d = pool_q;
            pool_d    = rdata[1];
            cnt_d     = cnt_q - ptr_t'(1);
            we[0]     = 1'b1;
            waddr[0]  = pool_q;
            wdata[0]  = NULL_PTR;
            if (app_tail != NULL_PTR) begin
              we[1]    = 1'b1;
              waddr[1] = app_tail;
              wdata[1] = pool_q;
            end
          end
        end else if (free_vld && free_rdy) begin
          if (free_head == NULL_PTR) begin
            free_done_d = 1'b1;
          end else if (full_bad) begin
            err_d       = 1'b1;
            free_done_d = 1'b1;
          end else begin
            state_d = WALK;
            cur_d   = free_head;
            head_d  = free_head;
            len_d   = ptr_t'(1);
          end
        end
      end
      WALK: begin
        if (rdata[1] != NULL_PTR) begin
          if (loop_bad) begin
            err_d       = 1'b1;
            free_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            cur_d = rdata[1];
            len_d = len_q + ptr_t'(1);
          end
        end else begin
          // Tail found: splice the whole list in front of the pool.
          we[0]       = 1'b1;
          waddr[0]    = cur_q;
          wdata[0]    = pool_q;
          pool_d      = head_q;
          cnt_d       = cnt_q + len_q;
          free_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_q       <= NULL_PTR;
      len_q       <= NULL_PTR;
      head_q      <= NULL_PTR;
      pool_q      <= ptr_t'(1);
      cnt_q       <= LAST_PTR;
      app_ptr_q   <= NULL_PTR;
      app_done_q  <= 1'b0;
      free_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      len_q       <= len_d;
      head_q      <= head_d;
      pool_q      <= pool_d;
      cnt_q       <= cnt_d;
      app_ptr_q   <= app_ptr_d;
      app_done_q  <= app_done_d;
      free_done_q <= free_done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_ll_list_builder.sv
// Bench for ll_list_builder: pool kept as an ordered queue, lists as
// head/tail/length records; directed literal checks then random traffic.
module tb_ll_list_builder;
  import ll_pkg::*;

`ifdef LL_BUILDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic app_vld = 1'b0, free_vld = 1'b0;
  ptr_t app_tail = '0, free_head = '0, rd_ptr = '0;
  logic app_rdy, app_done, free_rdy, free_done, err;
  ptr_t app_ptr, free_cnt, rd_next;

  always #5 clk = ~clk;

  ll_list_builder dut (
    .clk(clk), .rst_n(rst_n),
    .app_vld(app_vld), .app_tail(app_tail), .app_rdy(app_rdy),
    .app_done(app_done), .app_ptr(app_ptr),
    .free_vld(free_vld), .free_head(free_head), .free_rdy(free_rdy),
    .free_done(free_done), .free_cnt(free_cnt),
    .rd_ptr(rd_ptr), .rd_next(rd_next), .err(err)
  );

  int tests = 0, fails = 0;

  // Model state.
  ptr_t lnext [N];
  ptr_t pq [$];
  ptr_t wq [$];
  int   walk_left = 0;
  bit   lused [N];
  ptr_t lhead [N], ltail [N];
  int   llen [N];
  bit   e_app_done = 0, e_free_done = 0, e_err = 0;
  ptr_t e_app_ptr = '0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic ptr_t exp_next(ptr_t x);
    if (x == 0) return '0;
    for (int k = 0; k < pq.size(); k++)
      if (pq[k] == x) return (k == pq.size()-1) ? ptr_t'(0) : pq[k+1];
    return lnext[x];
  endfunction

  function automatic int pick();
    int cnt = 0, k, sel;
    for (int s = 0; s < N; s++) if (lused[s]) cnt++;
    if (cnt == 0) return -1;
    sel = $urandom_range(0, cnt-1);
    k = 0;
    for (int s = 0; s < N; s++)
      if (lused[s]) begin
        if (k == sel) return s;
        k++;
      end
    return -1;
  endfunction

  // One clock cycle: check registered outputs, drive, check comb outputs,
  // then apply the operation's effect to the model.
  task automatic step(input logic av, input ptr_t at, input logic fv,
                      input ptr_t fh, input ptr_t rp);
    bit   idle;
    ptr_t n, c;
    int   s;
    @(negedge clk);
    chk("app_done", app_done, e_app_done);
    if (e_app_done) chk("app_ptr", app_ptr, e_app_ptr);
    chk("free_done", free_done, e_free_done);
    chk("free_cnt", free_cnt, pq.size());
    chk("err", err, e_err);
    app_vld = av; app_tail = at; free_vld = fv; free_head = fh; rd_ptr = rp;
    #1;
    idle = (walk_left == 0);
    chk("app_rdy", app_rdy, idle && pq.size() != 0);
    chk("free_rdy", free_rdy, idle && !av);
    chk("rd_next", rd_next, exp_next(rp));
    e_app_done = 0;
    e_free_done = 0;
    if (!idle) begin
      walk_left--;
      if (walk_left == 0) begin
        pq = {wq, pq};
        e_free_done = 1;
      end
    end else if (av && pq.size() != 0) begin
      e_app_done = 1;
      if (CHK && at != 0 && lnext[at] != 0) begin
        e_app_ptr = '0;
        e_err = 1;
      end else begin
        n = pq.pop_front();
        lnext[n] = '0;
        e_app_ptr = n;
        if (at == 0) begin
          s = 0;
          while (lused[s]) s++;
          lused[s] = 1; lhead[s] = n; ltail[s] = n; llen[s] = 1;
        end else begin
          for (int k = 0; k < N; k++)
            if (lused[k] && ltail[k] == at) begin
              ltail[k] = n; llen[k]++;
            end
          lnext[at] = n;
        end
      end
    end else if (fv && !av) begin
      if (fh == 0) e_free_done = 1;
      else if (CHK && pq.size() == N-1) begin
        e_err = 1; e_free_done = 1;
      end else begin
        for (int k = 0; k < N; k++)
          if (lused[k] && lhead[k] == fh) begin
            lused[k] = 0;
            wq = {};
            c = fh;
            for (int j = 0; j < llen[k]; j++) begin
              wq.push_back(c);
              c = lnext[c];
            end
            walk_left = llen[k];
          end
      end
    end
  endtask

  task automatic idle_step(input ptr_t rp);
    step(1'b0, '0, 1'b0, '0, rp);
  endtask

  task automatic rand_step();
    logic av, fv;
    ptr_t at, fh;
    int   s;
    av = ($urandom_range(0, 1) == 1);
    at = '0;
    if ($urandom_range(0, 9) < 6) begin s = pick(); if (s >= 0) at = ltail[s]; end
    fv = ($urandom_range(0, 2) == 0);
    fh = '0;
    if ($urandom_range(0, 9) != 0) begin s = pick(); if (s >= 0) fh = lhead[s]; end
    step(av, at, fv, fh, ptr_t'($urandom_range(0, N-1)));
  endtask

  task automatic free_all();
    int s;
    for (int g = 0; g < N; g++) begin
      s = pick();
      if (s >= 0) begin
        step(1'b0, '0, 1'b1, lhead[s], '0);
        for (int w = 0; w < N && walk_left > 0; w++) idle_step('0);
        idle_step('0);
      end
    end
  endtask

  initial begin
    ptr_t n0, m0;
    for (int i = 0; i < N; i++) begin lnext[i] = '0; lused[i] = 0; end
    for (int i = 1; i < N; i++) pq.push_back(ptr_t'(i));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    idle_step(ptr_t'(1));
    chk("lit_rst_next1", rd_next, 2);
    chk("lit_rst_cnt", free_cnt, 15);
    chk("lit_rst_err", err, 0);
    idle_step(ptr_t'(15));
    chk("lit_rst_next15", rd_next, 0);

    // Build list 1->2.
    step(1'b1, '0, 1'b0, '0, '0);
    idle_step(ptr_t'(1));
    chk("lit_app1_ptr", app_ptr, 1);
    chk("lit_app1_cnt", free_cnt, 14);
    chk("lit_app1_next", rd_next, 0);
    step(1'b1, ptr_t'(1), 1'b0, '0, '0);
    idle_step(ptr_t'(1));
    chk("lit_app2_ptr", app_ptr, 2);
    chk("lit_app2_next1", rd_next, 2);
    idle_step(ptr_t'(2));
    chk("lit_app2_next2", rd_next, 0);

    // Free it: two walk cycles, then splice.
    step(1'b0, '0, 1'b1, ptr_t'(1), '0);
    idle_step('0);
    chk("lit_walk_rdy0", free_rdy, 0);
    idle_step('0);
    chk("lit_walk_rdy1", free_rdy, 0);
    idle_step(ptr_t'(2));
    chk("lit_free_done", free_done, 1);
    chk("lit_free_cnt", free_cnt, 15);
    chk("lit_free_next2", rd_next, 3);
    step(1'b1, '0, 1'b0, '0, '0);
    idle_step('0);
    chk("lit_reuse_ptr", app_ptr, 1);
    step(1'b0, '0, 1'b1, ptr_t'(1), '0);
    idle_step('0);
    idle_step('0);

    // Drain the pool.
    for (int i = 0; i < 15; i++) step(1'b1, '0, 1'b0, '0, '0);
    step(1'b1, '0, 1'b0, '0, '0);
    chk("lit_empty_rdy", app_rdy, 0);
    chk("lit_empty_cnt", free_cnt, 0);
    step(1'b1, '0, 1'b0, '0, '0);
    chk("lit_empty_hold", app_rdy, 0);
    step(1'b0, '0, 1'b1, ptr_t'(5), '0);
    idle_step('0);
    step(1'b1, '0, 1'b0, '0, '0);
    idle_step('0);
    chk("lit_refill_ptr", app_ptr, 5);

    // Append wins over a simultaneous free.
    step(1'b0, '0, 1'b1, ptr_t'(6), '0);
    idle_step('0);
    idle_step('0);
    step(1'b1, '0, 1'b1, ptr_t'(7), '0);
    chk("lit_both_frdy", free_rdy, 0);
    step(1'b0, '0, 1'b1, ptr_t'(7), '0);
    chk("lit_both_done", app_done, 1);
    chk("lit_both_ptr", app_ptr, 6);
    chk("lit_both_frdy2", free_rdy, 1);

    // Random traffic.
    for (int i = 0; i < 4000; i++) rand_step();
    for (int w = 0; w < N && walk_left > 0; w++) idle_step('0);
    free_all();
    idle_step(ptr_t'(1));

`ifdef LL_BUILDER_CHECK_EN
    // Free into a full pool.
    step(1'b0, '0, 1'b1, ptr_t'(3), '0);
    idle_step('0);
    chk("lit_full_err", err, 1);
    chk("lit_full_cnt", free_cnt, 15);
    // Append behind a non-tail node.
    n0 = pq[0];
    step(1'b1, '0, 1'b0, '0, '0);
    m0 = pq[0];
    step(1'b1, n0, 1'b0, '0, '0);
    step(1'b1, n0, 1'b0, '0, '0);
    idle_step(n0);
    chk("lit_bad_done", app_done, 1);
    chk("lit_bad_ptr", app_ptr, 0);
    chk("lit_bad_next", rd_next, m0);
    chk("lit_bad_cnt", free_cnt, 13);
`else
    n0 = '0; m0 = '0;
    chk("lit_err_off", err, n0 + m0);
`endif
    idle_step('0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
